// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: sequencer for the select (A) and enable (E) inputs of a
// downstream 3-to-8 decoder. Each enabled channel is held for div+1 cycles
// with E=1, followed by one blanking cycle with E=0 and A unchanged.
// Optional feature macro: SCAN_MASK_EN adds the 8-bit channel-skip mask port.
// Without it, all eight channels are scanned in order 0..7.
module decoder_scan_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
`ifdef SCAN_MASK_EN
  input  logic [7:0]       mask,
`endif
  output logic [2:0]       A,
  output logic             E,
  output logic             busy,
  output logic             sweep_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [2:0]       a_d;
  logic             e_d, busy_d, done_d;
  // Channel to load when the current BLANK ends, decided on entry to BLANK
  // so that sweep_done can be registered for the BLANK cycle itself.
  logic [2:0]       nxt_a_q, nxt_a_d;
  logic             go_q, go_d;

  logic [7:0]       en_mask;
  logic [3:0]       above;   // {found, channel}: next enabled channel above A
  logic [3:0]       lowest;  // {found, channel}: lowest enabled channel

`ifdef SCAN_MASK_EN
  assign en_mask = mask;
`else
  assign en_mask = 8'hFF;
`endif

  // Lowest set bit of m strictly above cur.
  function automatic logic [3:0] find_above(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Lowest set bit of m.
  function automatic logic [3:0] find_lowest(input logic [7:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign above  = find_above(en_mask, A);
  assign lowest = find_lowest(en_mask);

  // Next-state and next-output logic; stop overrides every state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = A;
    e_d     = E;
    busy_d  = busy;
    done_d  = 1'b0;
    nxt_a_d = nxt_a_q;
    go_d    = go_q;

    if (stop) begin
      state_d = IDLE;
      a_d     = 3'd0;
      e_d     = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_d    = 3'd0;
          e_d    = 1'b0;
          busy_d = 1'b0;
          // An empty mask leaves nothing to scan, so start is ignored.
          if (start && lowest[3]) begin
            mode_d  = mode;
            cnt_d   = div;
            a_d     = lowest[2:0];
            e_d     = 1'b1;
            busy_d  = 1'b1;
            state_d = DWELL;
          end
        end
        DWELL: begin
          if (cnt_q == '0) begin
            state_d = BLANK;
            e_d     = 1'b0;
            done_d  = ~above[3];
            if (above[3]) begin
              go_d    = 1'b1;
              nxt_a_d = above[2:0];
            end else if (!mode_q && lowest[3]) begin
              go_d    = 1'b1;
              nxt_a_d = lowest[2:0];
            end else begin
              go_d    = 1'b0;
              nxt_a_d = 3'd0;
            end
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        BLANK: begin
          if (go_q) begin
            state_d = DWELL;
            a_d     = nxt_a_q;
            cnt_d   = div;
            e_d     = 1'b1;
          end else begin
            state_d = IDLE;
            a_d     = 3'd0;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          a_d     = 3'd0;
          e_d     = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      A          <= 3'd0;
      E          <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      nxt_a_q    <= 3'd0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      A          <= a_d;
      E          <= e_d;
      busy       <= busy_d;
      sweep_done <= done_d;
      nxt_a_q    <= nxt_a_d;
      go_q       <= go_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl. Expected output traces are built
// from the scan schedule: each enabled channel contributes div+1 enabled
// cycles and one blank cycle; the last blank of a sweep carries sweep_done.
module tb_decoder_scan_ctrl;

  localparam int DIV_W = 8;
  localparam logic [5:0] IDLE_V = 6'd0;   // {A, E, busy, sweep_done}

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [7:0]       mask = 8'hFF;
  logic [2:0]       A;
  logic             E;
  logic             busy;
  logic             sweep_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  decoder_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .div        (div),
`ifdef SCAN_MASK_EN
    .mask       (mask),
`endif
    .A          (A),
    .E          (E),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs starting the cycle after start is sampled.
  task automatic build_expect(input int dv, input bit md, input logic [7:0] mk,
                              input int n, input bit hold);
    exp_q.delete();
    if (mk == 8'd0) begin
      while (exp_q.size() < n) exp_q.push_back(IDLE_V);
      return;
    end
    while (exp_q.size() < n) begin
      int last;
      last = 0;
      for (int c = 0; c < 8; c++) if (mk[c]) last = c;
      for (int c = 0; c < 8; c++) begin
        if (mk[c]) begin
          for (int k = 0; k <= dv; k++) exp_q.push_back({3'(c), 1'b1, 1'b1, 1'b0});
          exp_q.push_back({3'(c), 1'b0, 1'b1, (c == last)});
        end
      end
      if (md) begin
        exp_q.push_back(IDLE_V);
        if (!hold) while (exp_q.size() < n) exp_q.push_back(IDLE_V);
      end
    end
  endtask

  task automatic run_scan(input int dv, input bit md, input logic [7:0] mk,
                          input int n, input int stop_at, input bit hold,
                          input string name);
    logic [7:0] mk_eff;
`ifdef SCAN_MASK_EN
    mk_eff = mk;
`else
    mk_eff = 8'hFF;
`endif
    div  = DIV_W'(dv);
    mode = md;
    mask = mk;
    build_expect(dv, md, mk_eff, n, hold);
    if (stop_at >= 0)
      for (int i = stop_at + 1; i < exp_q.size(); i++) exp_q[i] = IDLE_V;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!hold) mode = 1'($urandom);
      check($sformatf("%s[%0d]", name, i), {26'd0, A, E, busy, sweep_done}, {26'd0, exp_q[i]});
      stop = (i == stop_at);
      step();
      stop = 1'b0;
    end
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    step();
    check({name, "_drain"}, {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});
  endtask

  initial begin
    int waited;
    // Reset state.
    #12;
    check("reset_state", {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});
    rst_n = 1'b1;
    step();
    check("idle_after_release", {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});

    // Start together with stop in IDLE stays IDLE.
    start = 1'b1; stop = 1'b1;
    step();
    check("start_stop_idle0", {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});
    step();
    check("start_stop_idle1", {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});
    start = 1'b0; stop = 1'b0;

    // Directed scans.
    run_scan(2, 1'b1, 8'hFF, 36, -1, 1'b0, "single_div2");
    run_scan(0, 1'b0, 8'hFF, 40, -1, 1'b0, "cont_div0");
    run_scan(1, 1'b1, 8'hFF, 30, 16, 1'b0, "stop_ch5");
    run_scan(1, 1'b1, 8'hFF, 60, -1, 1'b1, "start_held");
`ifdef SCAN_MASK_EN
    run_scan(1, 1'b1, 8'hA4, 14, -1, 1'b0, "mask_a4");
    run_scan(1, 1'b1, 8'h00, 10, -1, 1'b0, "mask_zero");
`endif

    // Randomized scans.
    for (int t = 0; t < 8; t++) begin
      int dv, sa;
      bit md, hd;
      logic [7:0] mk;
      dv = int'($urandom_range(0, 4));
      md = 1'($urandom);
      mk = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mk = 8'hFF;
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      hd = (sa < 0) ? 1'($urandom) : 1'b0;
      run_scan(dv, md, mk, 60, sa, hd, $sformatf("rand%0d", t));
    end

    // Asynchronous reset mid-dwell on channel 3.
    div = 8'd3; mode = 1'b1; mask = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    waited = 0;
    while (!(A == 3'd3 && E) && waited < 100) begin
      step();
      waited++;
    end
    check("reach_ch3_timeout", {31'd0, (waited < 100)}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_post_reset", {26'd0, A, E, busy, sweep_done}, {26'd0, IDLE_V});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
